// File: rtl/tpu_result_drain_if.sv
// Capture and byte-stream handshake bundle for the TPU result drain.
interface tpu_result_drain_if #(
  parameter int N     = 2,
  parameter int ACC_W = 16
);
  logic                   cap_valid;
  logic                   cap_ready;
  logic [N*N*ACC_W-1:0]   cap_data;
  logic                   relu;
  logic                   narrow;
  logic                   transpose;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_data;
  logic                   out_last;

  modport master (
    output cap_valid, cap_data, relu, narrow, transpose, out_ready,
    input  cap_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  cap_valid, cap_data, relu, narrow, transpose, out_ready,
    output cap_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/tpu_result_drain.sv
// Double-banked N x N accumulator tile drain: transform on capture, byte-serial
// MSB-first readout with optional transpose and registered output byte.
module tpu_result_drain_xform #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] din,
  input  logic             relu,
  input  logic             narrow,
  output logic [ACC_W-1:0] dout
);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-128);

  logic signed [ACC_W-1:0] v;

  always_comb begin
    v    = (relu && din[ACC_W-1]) ? '0 : $signed(din);
    dout = v;
    if (narrow) begin
      if (v > SMAX)      dout = ACC_W'(8'h7F);
      else if (v < SMIN) dout = ACC_W'(8'h80);
      else               dout = ACC_W'(v[7:0]);
    end
  end
endmodule

module tpu_result_drain #(
  parameter int N     = 2,
  parameter int ACC_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  tpu_result_drain_if.slave   bus,
  output logic                busy,
  output logic [7:0]          drop_cnt
);
  localparam int NN  = N * N;
  localparam int BPE = ACC_W / 8;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int BIW = (BPE > 1) ? $clog2(BPE) : 1;
  localparam int AW  = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic {IDLE, STREAM} state_t;
  typedef logic [NN-1:0][ACC_W-1:0] tile_t;

  tile_t             cap_el, cap_x, src;
  logic [1:0][NN-1:0][ACC_W-1:0] bank;
  logic [1:0]        bank_nar, bank_tr;
  logic              wr_ptr, rd_ptr, rd_nxt;
  logic [1:0]        count, count_nxt;
  state_t            state, state_nxt;
  logic [IW-1:0]     outer, inner, outer_nxt, inner_nxt;
  logic [BIW-1:0]    byte_idx, byte_nxt, bpe_last;
  logic [7:0]        data_q, data_nxt;
  logic              last_q, last_nxt;
  logic              cap_fire, fire, last_now, rel, src_nar, src_tr;

  function automatic logic last_of(input logic nar, input logic [IW-1:0] o,
                                   input logic [IW-1:0] in, input logic [BIW-1:0] b);
    return (o == IW'(N-1)) && (in == IW'(N-1)) && (b == (nar ? '0 : BIW'(BPE-1)));
  endfunction

  // outer/inner walk rows then columns; transpose just swaps their roles in the address
  function automatic logic [7:0] byte_at(input tile_t el, input logic nar, input logic tr,
                                         input logic [IW-1:0] o, input logic [IW-1:0] in,
                                         input logic [BIW-1:0] b);
    logic [AW-1:0] idx;
    int            sh;
    idx = tr ? AW'(int'(in) * N + int'(o)) : AW'(int'(o) * N + int'(in));
    sh  = nar ? 0 : (BPE - 1 - int'(b)) * 8;
    return 8'(el[idx] >> sh);
  endfunction

  assign cap_el = bus.cap_data;

  for (genvar e = 0; e < NN; e++) begin : g_xf
    tpu_result_drain_xform #(.ACC_W(ACC_W)) u_xf (
      .din(cap_el[e]), .relu(bus.relu), .narrow(bus.narrow), .dout(cap_x[e])
    );
  end

  assign bus.cap_ready = (count != 2'd2);
  assign bus.out_valid = (state == STREAM);
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign busy          = (count != 2'd0);

  always_comb begin
    cap_fire  = bus.cap_valid && bus.cap_ready;
    fire      = bus.out_valid && bus.out_ready;
    last_now  = last_of(bank_nar[rd_ptr], outer, inner, byte_idx);
    rel       = fire && last_now;
    count_nxt = count + 2'(cap_fire) - 2'(rel);
    rd_nxt    = rd_ptr ^ rel;
    bpe_last  = bank_nar[rd_ptr] ? '0 : BIW'(BPE-1);
    outer_nxt = outer;
    inner_nxt = inner;
    byte_nxt  = byte_idx;
    if (fire) begin
      if (last_now) begin
        outer_nxt = '0;
        inner_nxt = '0;
        byte_nxt  = '0;
      end else if (byte_idx != bpe_last) begin
        byte_nxt = byte_idx + 1'b1;
      end else begin
        byte_nxt = '0;
        if (inner != IW'(N-1)) inner_nxt = inner + 1'b1;
        else begin
          inner_nxt = '0;
          outer_nxt = outer + 1'b1;
        end
      end
    end
    state_nxt = (count_nxt != 2'd0) ? STREAM : IDLE;
    // A bank written this edge that is also the next one read must be bypassed
    if (cap_fire && (wr_ptr == rd_nxt)) begin
      src     = cap_x;
      src_nar = bus.narrow;
      src_tr  = bus.transpose;
    end else begin
      src     = bank[rd_nxt];
      src_nar = bank_nar[rd_nxt];
      src_tr  = bank_tr[rd_nxt];
    end
    data_nxt = 8'h00;
    last_nxt = 1'b0;
    if (state_nxt == STREAM) begin
      data_nxt = byte_at(src, src_nar, src_tr, outer_nxt, inner_nxt, byte_nxt);
      last_nxt = last_of(src_nar, outer_nxt, inner_nxt, byte_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      outer    <= '0;
      inner    <= '0;
      byte_idx <= '0;
      data_q   <= 8'h00;
      last_q   <= 1'b0;
      bank_nar <= '0;
      bank_tr  <= '0;
      drop_cnt <= 8'h00;
    end else begin
      count    <= count_nxt;
      rd_ptr   <= rd_nxt;
      outer    <= outer_nxt;
      inner    <= inner_nxt;
      byte_idx <= byte_nxt;
      data_q   <= data_nxt;
      last_q   <= last_nxt;
      if (cap_fire) begin
        bank_nar[wr_ptr] <= bus.narrow;
        bank_tr[wr_ptr]  <= bus.transpose;
        wr_ptr           <= ~wr_ptr;
      end
      if (bus.cap_valid && !bus.cap_ready && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'h01;
    end
  end

  // Tile payload needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (cap_fire) bank[wr_ptr] <= cap_x;
  end
endmodule

// File: tb/tb_tpu_result_drain.sv
// Scoreboard bench for tpu_result_drain (N=2, ACC_W=16): directed tiles with
// hand-computed byte streams, checked by an independent output monitor.
module tb_tpu_result_drain;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [7:0] drop_cnt;
  int         checks = 0;
  int         errors = 0;
  int         pops   = 0;
  logic [8:0] q[$];
  logic       stall = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;

  localparam logic [63:0] T1 = {16'h7FFF, 16'h0080, 16'hFFFE, 16'h1234};
  localparam logic [63:0] T2 = {16'hFFF0, 16'h0080, 16'hFE00, 16'h1234};

  tpu_result_drain_if #(.N(2), .ACC_W(16)) bus ();

  tpu_result_drain #(.N(2), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every transfer, and verifies hold during backpressure
  always @(negedge clk) begin
    if (!rst_n) stall = 1'b0;
    else begin
      if (stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(hold_d));
        chk("hold_last", 32'(bus.out_last), 32'(hold_l));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h want none at %0t", bus.out_data, $time);
        end else begin
          logic [8:0] e;
          e = q.pop_front();
          chk("byte", 32'(bus.out_data), 32'(e[7:0]));
          chk("last", 32'(bus.out_last), 32'(e[8]));
          pops++;
        end
      end
      stall  = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      hold_l = bus.out_last;
    end
  end

  // Called at posedge+#1; presents a tile for one edge and returns at posedge+#1
  task automatic cap(input logic [63:0] d, input logic r, input logic n, input logic t,
                     input logic acc, input int nb, input logic [63:0] bytes);
    bus.cap_data  = d;
    bus.relu      = r;
    bus.narrow    = n;
    bus.transpose = t;
    bus.cap_valid = 1'b1;
    @(negedge clk);
    chk("cap_ready", 32'(bus.cap_ready), 32'(acc));
    if (acc)
      for (int i = 0; i < nb; i++)
        q.push_back({(i == nb - 1), bytes[(nb-1-i)*8 +: 8]});
    @(posedge clk);
    #1;
    bus.cap_valid = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((q.size() != 0 || busy) && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_in_time", 32'(n < maxc), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cap_ready", 32'(bus.cap_ready), 32'd1);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.cap_valid = 1'b0;
    bus.cap_data  = '0;
    bus.relu      = 1'b0;
    bus.narrow    = 1'b0;
    bus.transpose = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Wide row-major, with first-byte latency
    chk("pre_valid", 32'(bus.out_valid), 32'd0);
    cap(T1, 0, 0, 0, 1, 8, 64'h1234_FFFE_0080_7FFF);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_data", 32'(bus.out_data), 32'h12);
    wait_drain(40);

    // Narrow, then narrow with ReLU
    cap(T2, 0, 1, 0, 1, 4, 64'h7F80_7FF0);
    wait_drain(40);
    cap(T2, 1, 1, 0, 1, 4, 64'h7F00_7F00);
    wait_drain(40);

    // Transposed readout
    cap(T1, 0, 0, 1, 1, 8, 64'h1234_0080_FFFE_7FFF);
    wait_drain(40);

    // Random backpressure across two queued tiles
    bus.out_ready = 1'b0;
    cap(T1, 0, 0, 0, 1, 8, 64'h1234_FFFE_0080_7FFF);
    cap(T1, 0, 0, 1, 1, 8, 64'h1234_0080_FFFE_7FFF);
    for (int i = 0; i < 300 && (q.size() != 0 || busy); i++) begin
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_drain(40);

    // Double buffer full, drop, drop_cnt saturation, gapless drain
    bus.out_ready = 1'b0;
    cap(T1, 0, 0, 0, 1, 8, 64'h1234_FFFE_0080_7FFF);
    cap(T1, 0, 0, 1, 1, 8, 64'h1234_0080_FFFE_7FFF);
    chk("full_cap_ready", 32'(bus.cap_ready), 32'd0);
    cap(T2, 0, 1, 0, 0, 4, 64'h0);
    chk("drop_one", 32'(drop_cnt), 32'd1);
    bus.cap_valid = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    bus.cap_valid = 1'b0;
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("no_gap", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("after16_valid", 32'(bus.out_valid), 32'd0);
    wait_drain(10);

    // Reset in the middle of a tile
    begin
      int p0, n;
      p0 = pops;
      n  = 0;
      cap(T1, 0, 0, 0, 1, 8, 64'h1234_FFFE_0080_7FFF);
      while (pops < p0 + 3 && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("three_bytes", 32'(pops - p0), 32'd3);
    end
    rst_n = 1'b0;
    q.delete();
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("no_residual", 32'(bus.out_valid), 32'd0);
    end
    cap(T2, 0, 1, 0, 1, 4, 64'h7F80_7FF0);
    wait_drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
